// File: rtl/timing_arb_pkg.sv
// ---------------------------------------------------------------------------
// timing_arb_pkg
// Shared definitions for the timing-buffer merge arbiter.
//   arb_state_e : arbiter state machine encoding
//   NEUTRAL     : all-ones channel value (sign bit set means "no token")
//   is_valid()  : a channel word carries a token when its sign bit is clear
// ---------------------------------------------------------------------------
package timing_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,   // waiting for any probe
        ACQ,    // receiver enable raised, waiting for valid data
        LRTZ,   // data captured, waiting for the sender to return to neutral
        SEND,   // waiting for the consumer enable
        RTZ     // token presented, waiting for the consumer to release
    } arb_state_e;

    // Wide enough for any practical payload; users slice the low bits.
    localparam logic [63:0] NEUTRAL = '1;

    function automatic logic is_valid(input logic msb);
        return !msb;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin search: returns the first set request at or
// above ptr, wrapping from NUM_IN-1 back to 0.
//   req   : request vector
//   ptr   : search start index
//   found : at least one request is set
//   grant : index of the selected request (0 when found is low)
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [$clog2(NUM_IN)-1:0] ptr,
    output logic                      found,
    output logic [$clog2(NUM_IN)-1:0] grant
);

    localparam int IDX_W = $clog2(NUM_IN);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise synthesis infers a latch to hold the missing cases.
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_IN);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/timing_buffer_merge_arbiter.sv
// ---------------------------------------------------------------------------
// timing_buffer_merge_arbiter
// Round-robin merge of NUM_IN four-phase timing-buffer channels onto one
// four-phase output channel, one token per grant. All outputs registered.
//   clk      : clock
//   reset    : synchronous active-high reset
//   l_req    : per-channel probe, 1 = token pending
//   l_data   : flattened input channels, channel i at [i*(BIT_WIDTH+1) +: BIT_WIDTH+1]
//   l_enable : per-channel receiver enable, one-hot or zero
//   r_data   : merged output, all ones when neutral
//   r_enable : consumer enable
//   busy     : high whenever the arbiter is not idle
//   r_src    : granted channel while r_data is valid, else 0
//              (present only with TIMING_ARB_SRC_TAG_EN defined)
// ---------------------------------------------------------------------------
module timing_buffer_merge_arbiter
    import timing_arb_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int BIT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_IN-1:0]                 l_req,
    input  logic [NUM_IN*(BIT_WIDTH+1)-1:0]   l_data,
    output logic [NUM_IN-1:0]                 l_enable,
    output logic signed [BIT_WIDTH:0]         r_data,
    input  logic                              r_enable,
    output logic                              busy
`ifdef TIMING_ARB_SRC_TAG_EN
    ,
    output logic [$clog2(NUM_IN)-1:0]         r_src
`endif
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam logic [BIT_WIDTH:0] NEUTRAL_W = NEUTRAL[BIT_WIDTH:0];

    arb_state_e         state, state_n;
    logic [IDX_W-1:0]   grant, grant_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [BIT_WIDTH:0] x, x_n;
    logic [NUM_IN-1:0]  l_enable_n;
    logic [BIT_WIDTH:0] r_data_n;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [BIT_WIDTH:0] l_data_ch [NUM_IN];
    logic [BIT_WIDTH:0] granted_data;
`ifdef TIMING_ARB_SRC_TAG_EN
    logic [IDX_W-1:0]   r_src_n;
`endif

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign l_data_ch[i] = l_data[i*(BIT_WIDTH+1) +: BIT_WIDTH+1];
    end

    // Only the committed channel is ever looked at.
    assign granted_data = l_data_ch[grant];

    rr_priority_picker #(.NUM_IN(NUM_IN)) u_picker (
        .req   (l_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .grant (pick_idx)
    );

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        rr_ptr_n   = rr_ptr;
        x_n        = x;
        l_enable_n = l_enable;
        r_data_n   = r_data;
`ifdef TIMING_ARB_SRC_TAG_EN
        r_src_n    = r_src;
`endif
        case (state)
            IDLE: if (pick_found) begin
                grant_n    = pick_idx;
                l_enable_n = NUM_IN'(1) << pick_idx;
                state_n    = ACQ;
            end
            ACQ: if (is_valid(granted_data[BIT_WIDTH])) begin
                x_n        = granted_data;
                l_enable_n = '0;
                state_n    = LRTZ;
            end
            LRTZ: if (!is_valid(granted_data[BIT_WIDTH])) begin
                state_n = SEND;
            end
            SEND: if (r_enable) begin
                r_data_n = x;
`ifdef TIMING_ARB_SRC_TAG_EN
                r_src_n  = grant;
`endif
                state_n  = RTZ;
            end
            RTZ: if (!r_enable) begin
                r_data_n = NEUTRAL_W;
`ifdef TIMING_ARB_SRC_TAG_EN
                r_src_n  = '0;
`endif
                rr_ptr_n = (grant == IDX_W'(NUM_IN-1)) ? '0 : grant + 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            // NOTE: the capture register is reset as well, so no X can ever
            // reach r_data even if a future change reads it earlier.
            x        <= NEUTRAL_W;
            l_enable <= '0;
            r_data   <= NEUTRAL_W;
            busy     <= 1'b0;
`ifdef TIMING_ARB_SRC_TAG_EN
            r_src    <= '0;
`endif
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            rr_ptr   <= rr_ptr_n;
            x        <= x_n;
            l_enable <= l_enable_n;
            r_data   <= r_data_n;
            busy     <= (state_n != IDLE);
`ifdef TIMING_ARB_SRC_TAG_EN
            r_src    <= r_src_n;
`endif
        end
    end

endmodule

// File: tb/tb_timing_buffer_merge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timing_buffer_merge_arbiter
// Directed bench: producers answer immediately on their receiver enable,
// the consumer is either automatic (enable = output neutral) or manual.
// ---------------------------------------------------------------------------
module tb_timing_buffer_merge_arbiter;
    import timing_arb_pkg::*;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam logic [BW:0] NEU = 9'h1FF;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        l_req = '0;
    logic [N*(BW+1)-1:0] l_data;
    logic [N-1:0]        l_enable;
    logic signed [BW:0]  r_data;
    logic                r_enable;
    logic                busy;
`ifdef TIMING_ARB_SRC_TAG_EN
    logic [1:0]          r_src;
`endif

    logic [BW:0] ch_val [N];
    logic        auto_cons = 1'b1;
    logic        man_r_en  = 1'b0;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [BW:0] mon_data [$];
    int          mon_cyc  [$];
    logic [1:0]  mon_src  [$];
    logic        prev_neutral = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar i = 0; i < N; i++) begin : g_prod
        assign l_data[i*(BW+1) +: BW+1] = l_enable[i] ? ch_val[i] : NEU;
    end
    assign r_enable = auto_cons ? r_data[BW] : man_r_en;

    timing_buffer_merge_arbiter #(.NUM_IN(N), .BIT_WIDTH(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .l_req    (l_req),
        .l_data   (l_data),
        .l_enable (l_enable),
        .r_data   (r_data),
        .r_enable (r_enable),
        .busy     (busy)
`ifdef TIMING_ARB_SRC_TAG_EN
        ,
        .r_src    (r_src)
`endif
    );

    // Record each rising of r_data from neutral to valid.
    always @(negedge clk) begin
        if (!reset && r_data[BW] == 1'b0 && prev_neutral) begin
            mon_data.push_back(r_data);
            mon_cyc.push_back(cyc);
`ifdef TIMING_ARB_SRC_TAG_EN
            mon_src.push_back(r_src);
`else
            mon_src.push_back(2'd0);
`endif
        end
        prev_neutral = r_data[BW];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_cyc.delete();
        mon_src.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (l_enable !== 4'b0000) $display("FAIL reset_l_enable cyc %0d got %b want 0000", c, l_enable);
            else passed++;
            total++;
            if (r_data !== NEU) $display("FAIL reset_r_data cyc %0d got %h want %h", c, r_data, NEU);
            else passed++;
            total++;
            if (busy !== 1'b0) $display("FAIL reset_busy cyc %0d got %b want 0", c, busy);
            else passed++;
        end
        total++;
        if (dut.rr_ptr !== 2'd0) $display("FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr);
        else passed++;
    endtask

    task automatic test_single_token();
        auto_cons = 1'b1;
        ch_val[2] = 9'h05A;
        l_req = 4'b0100;
        step();                                   // edge 0
        total++;
        if (l_enable !== 4'b0100) $display("FAIL single_l_enable got %b want 0100", l_enable);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy);
        else passed++;
        l_req = 4'b0000;
        step();                                   // edge 1
        total++;
        if (l_enable !== 4'b0000) $display("FAIL single_l_enable_low got %b want 0000", l_enable);
        else passed++;
        step();                                   // edge 2
        step();                                   // edge 3
        total++;
        if (r_data !== 9'h05A) $display("FAIL single_r_data got %h want 05a", r_data);
        else passed++;
        step();                                   // edge 4
        total++;
        if (r_data !== NEU) $display("FAIL single_r_rtz got %h want %h", r_data, NEU);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL single_idle got busy %b want 0", busy);
        else passed++;
        total++;
        if (dut.rr_ptr !== 2'd3) $display("FAIL single_rr_ptr got %0d want 3", dut.rr_ptr);
        else passed++;
    endtask

    task automatic test_wrap();
        int guard;
        clear_mon();
        ch_val[0] = 9'h010;
        ch_val[1] = 9'h011;
        l_req = 4'b0011;
        guard = 0;
        while (mon_data.size() < 2 && guard < 60) begin
            step();
            guard++;
        end
        l_req = 4'b0000;
        total++;
        if (mon_data.size() < 2) $display("FAIL wrap_timeout got %0d tokens want 2", mon_data.size());
        else begin
            passed++;
            total++;
            if (mon_data[0] !== 9'h010) $display("FAIL wrap_first got %h want 010", mon_data[0]);
            else passed++;
            total++;
            if (mon_data[1] !== 9'h011) $display("FAIL wrap_second got %h want 011", mon_data[1]);
            else passed++;
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 20) begin
            step();
            guard++;
        end
    endtask

    task automatic test_fairness();
        int guard;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_mon();
        for (int i = 0; i < N; i++) ch_val[i] = 9'(i);
        l_req = 4'b1111;
        guard = 0;
        while (mon_data.size() < 8 && guard < 100) begin
            step();
            guard++;
        end
        l_req = 4'b0000;
        total++;
        if (mon_data.size() < 8) $display("FAIL fair_timeout got %0d tokens want 8", mon_data.size());
        else begin
            passed++;
            for (int k = 0; k < 8; k++) begin
                total++;
                if (mon_data[k] !== 9'(k % N)) $display("FAIL fair_order token %0d got %h want %h", k, mon_data[k], 9'(k % N));
                else passed++;
`ifdef TIMING_ARB_SRC_TAG_EN
                total++;
                if (mon_src[k] !== 2'(k % N)) $display("FAIL fair_src token %0d got %0d want %0d", k, mon_src[k], k % N);
                else passed++;
`endif
                if (k > 0) begin
                    total++;
                    if (mon_cyc[k] - mon_cyc[k-1] != 5) $display("FAIL fair_spacing token %0d got %0d want 5", k, mon_cyc[k] - mon_cyc[k-1]);
                    else passed++;
                end
            end
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 20) begin
            step();
            guard++;
        end
    endtask

    task automatic test_stall();
        auto_cons = 1'b0;
        man_r_en  = 1'b0;
        ch_val[1] = 9'h022;
        l_req = 4'b0010;                          // rr_ptr is 0, channel 1 wins
        step();
        total++;
        if (l_enable !== 4'b0010) $display("FAIL stall_grant got %b want 0010", l_enable);
        else passed++;
        l_req = 4'b0000;
        step();
        step();                                   // now in SEND
        l_req = 4'b1001;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (dut.state !== SEND) $display("FAIL stall_state cyc %0d got %0d want %0d", c, dut.state, SEND);
            else passed++;
            total++;
            if (r_data !== NEU) $display("FAIL stall_r_data cyc %0d got %h want %h", c, r_data, NEU);
            else passed++;
            total++;
            if (l_enable !== 4'b0000) $display("FAIL stall_l_enable cyc %0d got %b want 0000", c, l_enable);
            else passed++;
        end
        l_req = 4'b0000;
        man_r_en = 1'b1;
        step();
        total++;
        if (r_data !== 9'h022) $display("FAIL stall_release got %h want 022", r_data);
        else passed++;
        man_r_en = 1'b0;
        step();
        total++;
        if (r_data !== NEU || busy !== 1'b0) $display("FAIL stall_rtz got r_data %h busy %b want %h 0", r_data, busy, NEU);
        else passed++;
        total++;
        if (dut.rr_ptr !== 2'd2) $display("FAIL stall_rr_ptr got %0d want 2", dut.rr_ptr);
        else passed++;
    endtask

    task automatic test_reset_mid();
        auto_cons = 1'b0;
        man_r_en  = 1'b0;
        ch_val[2] = 9'h011;
        l_req = 4'b0100;
        step();
        l_req = 4'b0000;
        step();
        step();                                   // SEND
        man_r_en = 1'b1;
        step();                                   // RTZ, token presented
        total++;
        if (r_data !== 9'h011) $display("FAIL mid_pre got %h want 011", r_data);
        else passed++;
        reset = 1'b1;
        step();
        total++;
        if (r_data !== NEU) $display("FAIL mid_r_data got %h want %h", r_data, NEU);
        else passed++;
        total++;
        if (l_enable !== 4'b0000) $display("FAIL mid_l_enable got %b want 0000", l_enable);
        else passed++;
        total++;
        if (dut.rr_ptr !== 2'd0) $display("FAIL mid_rr_ptr got %0d want 0", dut.rr_ptr);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy);
        else passed++;
        reset = 1'b0;
        man_r_en = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) ch_val[i] = '0;
        test_reset();
        test_single_token();
        test_wrap();
        test_fairness();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
